// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues in-order imem requests, buffers returned words for decode.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects raise fetch_fault and halt fetch.
module instr_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          BUF_DEPTH       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4,
  output logic [31:0] if_instr,
  output logic        fetch_fault
);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW  = $clog2(BUF_DEPTH + 1);
  localparam int AIW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int BIW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ibuf_t;

  state_t         state;
  logic           fault_q;
  logic [31:0]    fetch_pc;
  logic [OW-1:0]  outstanding, drop_cnt;
  logic [31:0]    afifo [MAX_OUTSTANDING];
  logic [AIW-1:0] a_wr, a_rd;
  ibuf_t          ibuf [BUF_DEPTH];
  logic [BIW-1:0] b_wr, b_rd;
  logic [BW-1:0]  b_cnt;

  logic [31:0] target;
  logic        misalign;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target   = redirect_pc;
  assign misalign = |redirect_pc[1:0];
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign target   = {redirect_pc[31:2], 2'b00};
  assign misalign = 1'b0;
`endif

  function automatic logic [AIW-1:0] a_inc(input logic [AIW-1:0] p);
    return (p == AIW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [BIW-1:0] b_inc(input logic [BIW-1:0] p);
    return (p == BIW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Live in-flight requests plus buffered words must fit the buffer, so responses never overflow it.
  logic [7:0] credit;
  assign credit = 8'(outstanding) - 8'(drop_cnt) + 8'(b_cnt);

  assign imem_req_valid = (state == RUN) && !redirect &&
                          (outstanding < OW'(MAX_OUTSTANDING)) && (credit < 8'(BUF_DEPTH));
  assign imem_req_addr  = fetch_pc;

  logic req_fire, rsp_push, pop;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_push = imem_rsp_valid && !redirect && (drop_cnt == '0);
  assign if_valid = (b_cnt != '0) && !redirect;
  assign pop      = if_valid && if_ready;

  assign if_pc        = ibuf[b_rd].pc;
  assign if_instr     = ibuf[b_rd].instr;
  assign if_pc_plus_4 = if_pc + 32'd4;
  assign fetch_fault  = fault_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      fault_q     <= 1'b0;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      a_wr        <= '0;
      a_rd        <= '0;
    end else begin
      case (state)
        IDLE:    state <= RUN;
        RUN:     if (redirect && misalign)  state <= HALT;
        HALT:    if (redirect && !misalign) state <= RUN;
        default: state <= IDLE;
      endcase
      if (redirect && state != IDLE) fault_q <= misalign;

      if (redirect)      fetch_pc <= target;
      else if (req_fire) fetch_pc <= fetch_pc + 32'd4;

      if (req_fire)       a_wr <= a_inc(a_wr);
      if (imem_rsp_valid) a_rd <= a_inc(a_rd);
      outstanding <= outstanding + OW'(req_fire) - OW'(imem_rsp_valid);

      // Everything still in flight after this cycle belongs to the old stream.
      if (redirect)                                drop_cnt <= outstanding - OW'(imem_rsp_valid);
      else if (imem_rsp_valid && drop_cnt != '0)   drop_cnt <= drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) afifo[a_wr] <= fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_wr  <= '0;
      b_rd  <= '0;
      b_cnt <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) ibuf[i] <= '0;
    end else if (redirect) begin
      b_wr  <= b_rd;
      b_cnt <= '0;
    end else begin
      if (rsp_push) begin
        ibuf[b_wr] <= '{pc: afifo[a_rd], instr: imem_rsp_data};
        b_wr       <= b_inc(b_wr);
      end
      if (pop) b_rd <= b_inc(b_rd);
      b_cnt <= b_cnt + BW'(rsp_push) - BW'(pop);
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: request-granting memory model, scoreboard of expected decode words.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_pc_plus_4, if_instr;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0), .MAX_OUTSTANDING(2), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_pc_plus_4(if_pc_plus_4), .if_instr(if_instr),
    .fetch_fault(fetch_fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend[$];
  int          vectors = 0, miscompares = 0;
  int          lim = 0, granted = 0;
  bit          hold = 1'b0;

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    e.instr = pc ^ 32'h5A5A_0F0F;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      cyc();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d words undelivered, want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) cyc();
  endtask

  // Memory: accepts only `lim` requests in total, answers one cycle later unless held.
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend.delete();
      else if (imem_req_valid && imem_req_ready) begin
        pend.push_back(imem_req_addr);
        granted++;
      end
      @(posedge clk);
      #1;
      imem_req_ready = (granted < lim);
      if (!hold && pend.size() > 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend.pop_front() ^ 32'h5A5A_0F0F;
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: every word taken by decode must be the next expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && if_valid && if_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: got pc %h instr %h, want no delivery", if_pc, if_instr);
        end else begin
          e = exp_q.pop_front();
          if (if_pc !== e.pc || if_pc_plus_4 !== e.pc4 || if_instr !== e.instr) begin
            miscompares++;
            $display("FAIL decode_word: got pc %h pc4 %h instr %h, want pc %h pc4 %h instr %h",
                     if_pc, if_pc_plus_4, if_instr, e.pc, e.pc4, e.instr);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    if_ready = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    check1("rst_req_valid", imem_req_valid, 1'b0);
    check ("rst_req_addr",  imem_req_addr,  32'h0);
    check1("rst_if_valid",  if_valid,       1'b0);
    check ("rst_if_pc",     if_pc,          32'h0);
    check ("rst_if_pc4",    if_pc_plus_4,   32'h4);
    check ("rst_if_instr",  if_instr,       32'h0);
    check1("rst_fault",     fetch_fault,    1'b0);

    // Sequential stream after reset release
    cyc();
    lim = 6; if_ready = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
    cyc();
    @(negedge clk);
    check1("first_req_valid", imem_req_valid, 1'b1);
    check ("first_req_addr",  imem_req_addr,  32'h0);
    drain("stream");

    // Decode back-pressure: buffer fills with 0x18/0x1C and requests stop
    if_ready = 1'b0; lim = 10;
    for (int i = 0; i < 4; i++) expect_pc(32'h18 + 32'(i * 4));
    repeat (7) cyc();
    @(negedge clk);
    check1("bp_req_stall", imem_req_valid, 1'b0);
    check1("bp_if_valid",  if_valid,       1'b1);
    check ("bp_if_pc",     if_pc,          32'h18);
    cyc();
    @(negedge clk);
    check ("bp_hold_pc",    if_pc,    32'h18);
    check ("bp_hold_instr", if_instr, 32'h5A5A_0F17);
    cyc();
    if_ready = 1'b1;
    drain("backpressure");

    // Redirect with two requests (0x28, 0x2C) outstanding
    hold = 1'b1; lim = 12;
    repeat (4) cyc();
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    check1("redir_no_req",   imem_req_valid, 1'b0);
    check1("redir_if_valid", if_valid,       1'b0);
    cyc();
    redirect = 1'b0; hold = 1'b0; lim = 15;
    expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h108);
    drain("redirect");

    // Redirect coincident with a response, then a second redirect before drops finish
    hold = 1'b1; lim = 17;
    repeat (4) cyc();
    hold = 1'b0;
    cyc();
    redirect = 1'b1; redirect_pc = 32'h300; hold = 1'b1; lim = 18;
    @(negedge clk);
    check1("redir_rsp_no_req", imem_req_valid, 1'b0);
    cyc();
    redirect = 1'b0;
    cyc();
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    check1("redir2_no_req", imem_req_valid, 1'b0);
    cyc();
    redirect = 1'b0; hold = 1'b0; lim = 21;
    expect_pc(32'h200); expect_pc(32'h204); expect_pc(32'h208);
    drain("double_redirect");

    // Flush of an occupied buffer, one-bubble redirect, PC wrap
    if_ready = 1'b0; lim = 23;
    repeat (6) cyc();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; lim = 26;
    @(negedge clk);
    check1("redir_hides_valid", if_valid,       1'b0);
    check1("redir_full_no_req", imem_req_valid, 1'b0);
    cyc();
    redirect = 1'b0; if_ready = 1'b1;
    expect_pc(32'hFFFF_FFF8); expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
    @(negedge clk);
    check1("redir_req_valid", imem_req_valid, 1'b1);
    check ("redir_req_addr",  imem_req_addr,  32'hFFFF_FFF8);
    drain("wrap");

    // Misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h102; lim = 28;
`ifdef FETCH_MISALIGN_CHECK_EN
    cyc();
    redirect = 1'b0;
    @(negedge clk);
    check1("fault_set",   fetch_fault,    1'b1);
    check1("halt_no_req", imem_req_valid, 1'b0);
    repeat (3) cyc();
    @(negedge clk);
    check1("halt_still_idle", imem_req_valid, 1'b0);
    cyc();
    redirect = 1'b1; redirect_pc = 32'h104;
    expect_pc(32'h104); expect_pc(32'h108);
    cyc();
    redirect = 1'b0;
    @(negedge clk);
    check1("fault_clear", fetch_fault,    1'b0);
    check1("resume_req",  imem_req_valid, 1'b1);
    check ("resume_addr", imem_req_addr,  32'h104);
`else
    expect_pc(32'h100); expect_pc(32'h104);
    cyc();
    redirect = 1'b0;
    @(negedge clk);
    check1("fault_tied",   fetch_fault,    1'b0);
    check1("aligned_req",  imem_req_valid, 1'b1);
    check ("aligned_addr", imem_req_addr,  32'h100);
`endif
    drain("misalign");

    // Reset asserted with words buffered
    if_ready = 1'b0; lim = 30;
    repeat (5) cyc();
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    check1("midrst_if_valid",  if_valid,       1'b0);
    check1("midrst_req_valid", imem_req_valid, 1'b0);
    check ("midrst_req_addr",  imem_req_addr,  32'h0);
    check ("midrst_if_pc",     if_pc,          32'h0);
    check ("midrst_if_pc4",    if_pc_plus_4,   32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
